pipe_mdu: RTL and testbench
===========================

PIPE_MDU -- requirements
Module: pipe_mdu

Interface
REQ-001 The block SHALL have one parameter: CNTW, default 5, iteration-counter width, giving 2^CNTW = 32 iterations.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: the EXE stage holds a mult/multu/div/divu instruction.
REQ-005 The block SHALL have port eop, input, 2 bits: operation select, 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 The block SHALL have ports ea and eb, inputs, 32 bits each: EXE operands; ea is the multiplicand or dividend, eb the multiplier or divisor.
REQ-007 The block SHALL have ports mthi and mtlo, inputs, 1 bit each: write ea into hi or lo.
REQ-008 The block SHALL have port cancel, input, 1 bit: pipeline flush; aborts any operation.
REQ-009 The block SHALL have ports hi and lo, outputs, 32 bits each: the architectural HI/LO registers.
REQ-010 The block SHALL have port busy, output, 1 bit: combinational stall request to the pipeline.
REQ-011 The block SHALL have port done, output, 1 bit: combinational; high in the cycle whose closing edge writes hi/lo or flags divide-by-zero.
REQ-012 The block SHALL have port dz, output, 1 bit: divide-by-zero flag, qualified by done.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, MUL (shift-add multiply) and DIV (restoring divide).
REQ-014 Accept: when state is IDLE, start=1 and cancel=0, the block SHALL latch operands at the edge and go to MUL or DIV with the counter at 0.
REQ-015 Operand latching SHALL use absolute values for signed ops (mult, div) and record result signs; eop is ignored when start=0.
REQ-016 Each MUL/DIV cycle SHALL perform one iteration and increment the counter; the cycle with counter=31 is the final cycle.
REQ-017 busy SHALL equal (IDLE & start & ~cancel & ~divzero) | (state!=IDLE & counter!=31), where divzero = eop[1] & (eb==0).
REQ-018 Timing: busy SHALL be high for 32 cycles (the accept cycle plus iterations 0..30), so the instruction leaves EXE at the end of the final cycle and is never re-accepted.
REQ-019 In the final cycle the block SHALL drive done=1 and write hi/lo at the closing edge, then return to IDLE; a dependent mfhi/mflo in the next cycle SHALL see the new values.
REQ-020 Multiply: {hi,lo} SHALL be the 64-bit product, negated for mult when the operand signs differ.
REQ-021 Divide: lo SHALL be the quotient (negated if signs differ) and hi the remainder (sign of the dividend); 0x80000000 div 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-022 Divide-by-zero: in IDLE with start & divzero & ~cancel, the block SHALL drive done=1 and dz=1 in that same cycle, keep busy=0, leave hi/lo unchanged, and stay in IDLE.
REQ-023 cancel=1 in any state SHALL force IDLE at the next edge, suppress done and any hi/lo write, and keep busy=0 in that cycle.
REQ-024 mthi/mtlo SHALL write ea only in IDLE with start=0 and cancel=0; otherwise they are ignored; mthi and mtlo together write both registers.
REQ-025 start asserted outside IDLE SHALL be ignored, with no restart and no operand reload.

Reset
REQ-026 resetn=0 SHALL immediately force state IDLE, counter 0, hi=lo=0, and all internal operand registers to 0, regardless of clock.
REQ-027 During reset busy=0, done=0 and dz=0; reset mid-operation SHALL discard the operation with no done pulse after release.

Verification
REQ-028 Reset: assert resetn=0 at any time -> hi=lo=0, busy=0, done=0 asynchronously.
REQ-029 Multiply: mult ea=0xFFFFFFFF, eb=2 -> busy high for exactly 32 cycles, done in cycle 32, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=1, lo=0xFFFFFFFE.
REQ-030 Divide: div ea=0xFFFFFFF9 (-7), eb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu ea=7, eb=2 -> lo=3, hi=1; div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 Divide-by-zero: hi=0x11, lo=0x22, divu with eb=0 -> done=1, dz=1, busy=0 in the same cycle; hi/lo unchanged.
REQ-032 Cancel: cancel=1 at iteration 10 of a mult -> IDLE next cycle, busy=0, no done, hi/lo keep their prior values.
REQ-033 Writes and reset: mthi with ea=0xABCD during a DIV -> ignored; mtlo with ea=5 in IDLE -> lo=5 next cycle; resetn pulsed low at iteration 20 -> hi=lo=0 and no done after release.

Source files
------------

// File: rtl/pipe_mdu.sv
// rtl/pipe_mdu.sv - iterative multiply/divide unit with HI/LO registers for a 5-stage pipeline
// One iteration per cycle: shift-add multiply or restoring divide on magnitudes, signs fixed on write-back.
module pipe_mdu #(
  parameter int CNTW = 5
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  eop,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t            state, state_n;
  logic [CNTW-1:0]   cnt;
  logic [31:0]       ph, pl, opb;
  logic              neg_q, neg_r;

  logic              idle, last, divzero, accept, wr_result, mt_ok;
  logic              a_sgn, b_sgn;
  logic [31:0]       a_abs, b_abs;

  assign idle    = (state == IDLE);
  assign last    = (cnt == {CNTW{1'b1}});
  assign divzero = eop[1] & (eb == 32'd0);
  assign accept  = idle & start & ~cancel & ~divzero;
  assign wr_result = ~idle & last & ~cancel;
  assign mt_ok   = idle & ~start & ~cancel;

  // eop[0]=0 selects the signed variants
  assign a_sgn = ~eop[0] & ea[31];
  assign b_sgn = ~eop[0] & eb[31];
  assign a_abs = a_sgn ? (~ea + 32'd1) : ea;
  assign b_abs = b_sgn ? (~eb + 32'd1) : eb;

  // Multiply: ph accumulates the upper half, pl shifts the multiplier out as product bits shift in
  logic [32:0] mul_sum;
  logic [31:0] mul_ph, mul_pl;
  assign mul_sum = {1'b0, ph} + (pl[0] ? {1'b0, opb} : 33'd0);
  assign mul_ph  = mul_sum[32:1];
  assign mul_pl  = {mul_sum[0], pl[31:1]};

  // Divide: ph is the partial remainder, pl shifts dividend bits out and quotient bits in
  logic [32:0] div_sh;
  logic        div_ok;
  logic [31:0] div_ph, div_pl;
  assign div_sh = {ph, pl[31]};
  assign div_ok = (div_sh >= {1'b0, opb});
  assign div_ph = div_ok ? 32'(div_sh - {1'b0, opb}) : div_sh[31:0];
  assign div_pl = {pl[30:0], div_ok};

  logic [31:0] it_ph, it_pl;
  assign it_ph = (state == MUL) ? mul_ph : div_ph;
  assign it_pl = (state == MUL) ? mul_pl : div_pl;

  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s;
  assign prod_s = neg_q ? (~{mul_ph, mul_pl} + 64'd1) : {mul_ph, mul_pl};
  assign quo_s  = neg_q ? (~div_pl + 32'd1) : div_pl;
  assign rem_s  = neg_r ? (~div_ph + 32'd1) : div_ph;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    dz      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          if (divzero) begin
            done = 1'b1;
            dz   = 1'b1;
          end else begin
            busy    = 1'b1;
            state_n = eop[1] ? DIV : MUL;
          end
        end
      end
      MUL, DIV: begin
        if (cancel) begin
          state_n = IDLE;
        end else if (last) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!resetn) begin
      busy = 1'b0;
      done = 1'b0;
      dz   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      ph    <= '0;
      pl    <= '0;
      opb   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        ph    <= '0;
        pl    <= eop[1] ? a_abs : b_abs;
        opb   <= eop[1] ? b_abs : a_abs;
        neg_q <= a_sgn ^ b_sgn;
        neg_r <= a_sgn;
      end else if (!idle && !cancel) begin
        cnt <= cnt + 1'b1;
        ph  <= it_ph;
        pl  <= it_pl;
      end else if (cancel) begin
        cnt <= '0;
      end

      if (wr_result) begin
        if (state == MUL) begin
          hi <= prod_s[63:32];
          lo <= prod_s[31:0];
        end else begin
          hi <= rem_s;
          lo <= quo_s;
        end
      end else if (mt_ok) begin
        if (mthi) hi <= ea;
        if (mtlo) lo <= ea;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mdu.sv
// tb/tb_pipe_mdu.sv - randomized self-checking bench for pipe_mdu
// Expected results come from native 64-bit arithmetic on the instruction semantics.
module tb_pipe_mdu;

  logic        clock = 1'b0;
  logic        resetn, start, mthi, mtlo, cancel;
  logic [1:0]  eop;
  logic [31:0] ea, eb, hi, lo;
  logic        busy, done, dz;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_mdu #(.CNTW(5)) dut (
    .clock(clock), .resetn(resetn), .start(start), .eop(eop), .ea(ea), .eb(eb),
    .mthi(mthi), .mtlo(mtlo), .cancel(cancel), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .dz(dz)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] xh, output logic [31:0] xl);
    longint     sa, sb, sq, sr;
    logic [63:0] p, q64, r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); xh = p[63:32]; xl = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; xh = p[63:32]; xl = p[31:0]; end
      2'b10: begin
        sq = sa / sb; sr = sa % sb;
        q64 = 64'(sq); r64 = 64'(sr);
        xl = q64[31:0]; xh = r64[31:0];
      end
      default: begin xl = a / b; xh = a % b; end
    endcase
  endtask

  // Drives one instruction, holds it through the stall, checks timing and the written result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] xh, input logic [31:0] xl, input bit chain);
    int nb;
    int kd;
    start = 1'b1; eop = op; ea = a; eb = b;
    nb = 0; kd = -1;
    for (int k = 0; k <= 40; k++) begin
      #2;
      if (busy) nb++;
      if (done) begin
        kd = k;
        break;
      end
      cyc();
    end
    n_cmp++;
    if (kd !== 32) begin
      n_bad++;
      $display("FAIL done_cycle op=%0d: got %0d, expected 32", op, kd);
    end
    n_cmp++;
    if (nb !== 32) begin
      n_bad++;
      $display("FAIL busy_cycles op=%0d: got %0d, expected 32", op, nb);
    end
    n_cmp++;
    if (dz !== 1'b0) begin
      n_bad++;
      $display("FAIL dz_on_done op=%0d: got %b, expected 0", op, dz);
    end
    cyc();
    if (!chain) start = 1'b0;
    #2;
    n_cmp++;
    if (hi !== xh || lo !== xl) begin
      n_bad++;
      $display("FAIL result op=%0d a=%h b=%h: got hi=%h lo=%h, expected hi=%h lo=%h",
               op, a, b, hi, lo, xh, xl);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b1; eop = 2'b00; ea = 32'd3; eb = 32'd5;
    mthi = 1'b0; mtlo = 1'b0; cancel = 1'b0;
    #2;
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b, expected all 0",
               hi, lo, busy, done, dz);
    end
    cyc(); cyc();
    resetn = 1'b1; start = 1'b0; mthi = 1'b1; mtlo = 1'b1; ea = 32'h1234;
    cyc();
    mthi = 1'b0; mtlo = 1'b0;
    #3;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b, expected 0", hi, lo, busy, done);
    end
    cyc();
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    run_op(2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op(2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(2'b11, 32'd7,        32'd2, 32'd1,        32'd3,        1'b0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] a, b, xh, xl;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 1) == 1) b = $urandom_range(1, 40);
      if ($urandom_range(0, 3) == 0) b = ~b + 32'd1;
      if (op[1] && b == 32'd0) b = 32'd1;
      model(op, a, b, xh, xl);
      run_op(op, a, b, xh, xl, i != 9);
    end
  endtask

  task automatic test_divzero();
    ea = 32'h11; mthi = 1'b1; cyc(); mthi = 1'b0;
    ea = 32'h22; mtlo = 1'b1; cyc(); mtlo = 1'b0;
    start = 1'b1; eop = 2'b11; ea = 32'd9; eb = 32'd0;
    #2;
    n_cmp++;
    if (done !== 1'b1 || dz !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL divzero_flags: got done=%b dz=%b busy=%b, expected 1 1 0", done, dz, busy);
    end
    cyc();
    start = 1'b0;
    #2;
    n_cmp++;
    if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL divzero_keep: got hi=%h lo=%h busy=%b done=%b, expected 11 22 0 0",
               hi, lo, busy, done);
    end
  endtask

  task automatic test_cancel();
    int seen;
    ea = 32'h55; mthi = 1'b1; cyc(); mthi = 1'b0;
    ea = 32'h66; mtlo = 1'b1; cyc(); mtlo = 1'b0;
    start = 1'b1; eop = 2'b00; ea = 32'd3; eb = 32'd4;
    for (int k = 0; k < 11; k++) cyc();
    cancel = 1'b1;
    #2;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel_cycle: got busy=%b done=%b, expected 0 0", busy, done);
    end
    cyc();
    cancel = 1'b0; eop = 2'b11; eb = 32'd0;
    #2;
    n_cmp++;
    if (dz !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel_idle: got dz=%b busy=%b, expected 1 0", dz, busy);
    end
    cyc();
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (done) seen++;
      cyc();
    end
    n_cmp++;
    if (seen !== 0 || hi !== 32'h55 || lo !== 32'h66) begin
      n_bad++;
      $display("FAIL cancel_result: got done_pulses=%0d hi=%h lo=%h, expected 0 55 66", seen, hi, lo);
    end
  endtask

  task automatic test_writes();
    int kd;
    int seen;
    start = 1'b1; eop = 2'b11; ea = 32'd100; eb = 32'd7;
    for (int k = 0; k < 5; k++) cyc();
    mthi = 1'b1; ea = 32'hABCD;
    kd = -1;
    for (int k = 5; k <= 40; k++) begin
      #2;
      if (done) begin
        kd = k;
        break;
      end
      cyc();
    end
    cyc();
    start = 1'b0; mthi = 1'b0;
    #2;
    n_cmp++;
    if (kd !== 32 || hi !== 32'd2 || lo !== 32'd14) begin
      n_bad++;
      $display("FAIL mthi_ignored: got done_cycle=%0d hi=%h lo=%h, expected 32 2 e", kd, hi, lo);
    end
    mtlo = 1'b1; ea = 32'd5;
    cyc();
    mtlo = 1'b0;
    #2;
    n_cmp++;
    if (lo !== 32'd5 || hi !== 32'd2) begin
      n_bad++;
      $display("FAIL mtlo_idle: got hi=%h lo=%h, expected 2 5", hi, lo);
    end
    start = 1'b1; eop = 2'b01; ea = 32'd1000; eb = 32'd1000;
    for (int k = 0; k < 21; k++) cyc();
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL midop_reset: got hi=%h lo=%h busy=%b done=%b, expected 0", hi, lo, busy, done);
    end
    cyc();
    resetn = 1'b1; start = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (done || busy) seen++;
      cyc();
    end
    n_cmp++;
    if (seen !== 0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++;
      $display("FAIL after_reset: got activity=%0d hi=%h lo=%h, expected 0 0 0", seen, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_divzero();
    test_cancel();
    test_writes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
